// File: rtl/neuron_lut_pkg.sv
// Shared sizing helpers and FSM encoding for the neuron lookup-table loader.
package neuron_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } lut_state_t;

  function automatic int entries(input int in_bits);
    return 1 << in_bits;
  endfunction

  function automatic int entries_per_word(input int cfg_w, input int out_bits);
    return cfg_w / out_bits;
  endfunction

  function automatic int num_words(input int in_bits, input int cfg_w, input int out_bits);
    return entries(in_bits) / entries_per_word(cfg_w, out_bits);
  endfunction

  localparam int ENTRIES          = entries(8);
  localparam int ENTRIES_PER_WORD = entries_per_word(16, 2);
  localparam int NUM_WORDS        = num_words(8, 16, 2);

endpackage

// File: rtl/neuron_lut_ram.sv
// Distributed table storage: one config-word-wide write port, one single-entry async read port.
// Contents are deliberately left unreset.
module neuron_lut_ram #(
  parameter int IN_BITS          = 8,
  parameter int OUT_BITS         = 2,
  parameter int ENTRIES_PER_WORD = 8,
  parameter int NUM_WORDS        = 32,
  parameter int WA               = 5
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [WA-1:0]                         waddr,
  input  logic [ENTRIES_PER_WORD*OUT_BITS-1:0]  wdata,
  input  logic [IN_BITS-1:0]                    raddr,
  output logic [OUT_BITS-1:0]                   rdata
);
  localparam int EB = $clog2(ENTRIES_PER_WORD);

  logic [ENTRIES_PER_WORD-1:0][OUT_BITS-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Upper address bits pick the stored word, lower bits pick the entry within it.
  assign rdata = mem[raddr[IN_BITS-1:EB]][raddr[EB-1:0]];

endmodule

// File: rtl/neuron_lut_loader.sv
// Loads a packed lookup table from a config stream, then serves lookups from it.
// Latency: one cycle from lookup accept to out_valid; lookups backpressured by out_ready.
module neuron_lut_loader
  import neuron_lut_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  output logic                loaded,
  output logic                cfg_error,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);
  localparam int E  = entries_per_word(CFG_W, OUT_BITS);
  localparam int NW = num_words(IN_BITS, CFG_W, OUT_BITS);
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

  lut_state_t          state;
  logic [CW-1:0]       word_cnt;
  logic                cfg_acc;
  logic                in_acc;
  logic                last_word;
  logic [OUT_BITS-1:0] rd_data;

  // A restart pulse wins over any coincident config word or lookup.
  assign cfg_ready = (state == ST_LOAD) && !cfg_start;
  assign in_ready  = (state == ST_SERVE) && !cfg_start && (!out_valid || out_ready);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign in_acc    = in_valid && in_ready;
  assign last_word = (word_cnt == LAST_WORD);

  neuron_lut_ram #(
    .IN_BITS         (IN_BITS),
    .OUT_BITS        (OUT_BITS),
    .ENTRIES_PER_WORD(E),
    .NUM_WORDS       (NW),
    .WA              (CW)
  ) u_ram (
    .clk  (clk),
    .we   (cfg_acc),
    .waddr(word_cnt),
    .wdata(cfg_data[E*OUT_BITS-1:0]),
    .raddr(in_data),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      loaded    <= 1'b0;
      cfg_error <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cfg_start) begin
      state     <= ST_LOAD;
      word_cnt  <= '0;
      loaded    <= 1'b0;
      cfg_error <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (cfg_acc) begin
            // Framing must put cfg_last on exactly the final word.
            if (cfg_last != last_word) begin
              cfg_error <= 1'b1;
              state     <= ST_IDLE;
            end else if (last_word) begin
              state  <= ST_SERVE;
              loaded <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (in_acc) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
